// File: rtl/layer_sequencer_if.sv
// Handshake and control bundle between the pass controller, the layer sequencer
// and the MAC array / store-register datapath.
interface layer_sequencer_if;
  logic        start;
  logic [5:0]  n_in0;
  logic [3:0]  n_layers;
  logic        busy;
  logic        done;
  logic        mac_clr;
  logic        mac_en;
  logic [4:0]  in_idx;
  logic        src_sel;
  logic [31:0] input_sel;
  logic        ld_val;
  logic        t;
  logic [3:0]  layer_idx;

  modport master (
    output start, n_in0, n_layers,
    input  busy, done, mac_clr, mac_en, in_idx, src_sel, input_sel, ld_val, t, layer_idx
  );

  modport slave (
    input  start, n_in0, n_layers,
    output busy, done, mac_clr, mac_en, in_idx, src_sel, input_sel, ld_val, t, layer_idx
  );
endinterface

// File: rtl/layer_sequencer.sv
// Multi-layer forward-pass sequencer: clear, accumulate, drain, load per layer,
// flipping the ping-pong store bank between layers. Every output is a flop.
module layer_sequencer #(
  parameter int unsigned N_NEURONS = 10,
  parameter int unsigned MAC_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  layer_sequencer_if.slave bus
);
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned LAY_W = 4;
  localparam int unsigned LAT_W = 3;
  localparam int unsigned SEL_W = 32;
  localparam logic [LAT_W-1:0] DRAIN_LAST = LAT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam logic [IDX_W-1:0] NEUR_LAST  = IDX_W'(N_NEURONS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_LOAD, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   n_in_q, n_in_nxt;
  logic [LAY_W-1:0]   n_lay_q, n_lay_nxt;
  logic [LAY_W-1:0]   layer_q, layer_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [LAT_W-1:0]   drain_q, drain_nxt;
  logic               t_q, t_nxt;
  logic               src_q, src_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               clr_q, clr_nxt;
  logic               en_q, en_nxt;
  logic               ld_q, ld_nxt;
  logic [SEL_W-1:0]   sel_q, sel_nxt;
  logic [CNT_W-1:0]   n_in_san_c;
  logic [LAY_W-1:0]   n_lay_san_c;
  logic [IDX_W-1:0]   last_idx_c;

  // Clamp the requested counts into their legal ranges before latching.
  always_comb begin
    n_in_san_c  = bus.n_in0;
    if (bus.n_in0 == 6'd0)       n_in_san_c = 6'd1;
    else if (bus.n_in0 > 6'd32)  n_in_san_c = 6'd32;
    n_lay_san_c = (bus.n_layers == 4'd0) ? 4'd1 : bus.n_layers;
    last_idx_c  = (layer_q == 4'd0) ? IDX_W'(n_in_q - 6'd1) : NEUR_LAST;
  end

  // Next state and next registered outputs; outputs describe the state being entered.
  always_comb begin
    state_nxt = state;
    n_in_nxt  = n_in_q;
    n_lay_nxt = n_lay_q;
    layer_nxt = layer_q;
    idx_nxt   = idx_q;
    drain_nxt = drain_q;
    t_nxt     = t_q;
    src_nxt   = src_q;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    en_nxt    = 1'b0;
    ld_nxt    = 1'b0;
    sel_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          n_in_nxt  = n_in_san_c;
          n_lay_nxt = n_lay_san_c;
          layer_nxt = '0;
          idx_nxt   = '0;
          src_nxt   = 1'b0;
          state_nxt = S_CLEAR;
          clr_nxt   = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_CLEAR: begin
        state_nxt = S_ACCUM;
        busy_nxt  = 1'b1;
        en_nxt    = 1'b1;
        sel_nxt   = SEL_W'(1) << idx_q;
      end
      S_ACCUM: begin
        busy_nxt = 1'b1;
        if (idx_q == last_idx_c) begin
          drain_nxt = '0;
          if (MAC_LAT == 0) begin
            state_nxt = S_LOAD;
            ld_nxt    = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else begin
          idx_nxt = idx_q + 5'd1;
          en_nxt  = 1'b1;
          sel_nxt = SEL_W'(1) << idx_nxt;
        end
      end
      S_DRAIN: begin
        busy_nxt = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_nxt = S_LOAD;
          ld_nxt    = 1'b1;
        end else begin
          drain_nxt = drain_q + 3'd1;
        end
      end
      S_LOAD: begin
        busy_nxt = 1'b1;
        t_nxt    = ~t_q;
        if (layer_q == n_lay_q - 4'd1) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          layer_nxt = layer_q + 4'd1;
          idx_nxt   = '0;
          src_nxt   = 1'b1;
          state_nxt = S_CLEAR;
          clr_nxt   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      n_in_q  <= '0;
      n_lay_q <= '0;
      layer_q <= '0;
      idx_q   <= '0;
      drain_q <= '0;
      t_q     <= 1'b0;
      src_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      ld_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state   <= state_nxt;
      n_in_q  <= n_in_nxt;
      n_lay_q <= n_lay_nxt;
      layer_q <= layer_nxt;
      idx_q   <= idx_nxt;
      drain_q <= drain_nxt;
      t_q     <= t_nxt;
      src_q   <= src_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      clr_q   <= clr_nxt;
      en_q    <= en_nxt;
      ld_q    <= ld_nxt;
      sel_q   <= sel_nxt;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mac_clr   = clr_q;
  assign bus.mac_en    = en_q;
  assign bus.in_idx    = idx_q;
  assign bus.src_sel   = src_q;
  assign bus.input_sel = sel_q;
  assign bus.ld_val    = ld_q;
  assign bus.t         = t_q;
  assign bus.layer_idx = layer_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (MAC_LAT=1/N=10 and MAC_LAT=0/N=5)
// compared cycle by cycle against a trace generated from the pass rules.
module tb_layer_sequencer;
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        clr;
    logic        en;
    logic        ld;
    logic        src;
    logic        t;
    logic [4:0]  idx;
    logic [3:0]  layer;
    logic [31:0] sel;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t msk_q[$];
  rec_t got_q[$];
  logic mt [2];

  always #5 clk = ~clk;

  layer_sequencer_if ifa();
  layer_sequencer_if ifb();

  layer_sequencer #(.N_NEURONS(10), .MAC_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  layer_sequencer #(.N_NEURONS(5),  .MAC_LAT(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic rec_t sample(input bit which);
    rec_t r;
    if (!which)
      r = {ifa.busy, ifa.done, ifa.mac_clr, ifa.mac_en, ifa.ld_val, ifa.src_sel, ifa.t,
           ifa.in_idx, ifa.layer_idx, ifa.input_sel};
    else
      r = {ifb.busy, ifb.done, ifb.mac_clr, ifb.mac_en, ifb.ld_val, ifb.src_sel, ifb.t,
           ifb.in_idx, ifb.layer_idx, ifb.input_sel};
    return r;
  endfunction

  function automatic void push(input rec_t e, input rec_t m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endfunction

  // Expected per-cycle trace from cycle 1 (CLEAR) through DONE plus 'tail' idle cycles.
  function automatic void build(input bit which, input int n_in0, input int nl, input int tail);
    int   nn  = which ? 5 : 10;
    int   lat = which ? 0 : 1;
    int   nin = (n_in0 == 0) ? 1 : ((n_in0 > 32) ? 32 : n_in0);
    int   nlay = (nl == 0) ? 1 : nl;
    logic tt = mt[which];
    rec_t e, m_full, m_ctl, m_tail;
    m_full = '1;
    m_ctl = '1;  m_ctl.idx = '0;  m_ctl.src = 1'b0;
    m_tail = m_ctl; m_tail.layer = '0;
    exp_q.delete(); msk_q.delete();
    for (int l = 0; l < nlay; l++) begin
      int n = (l == 0) ? nin : nn;
      e = '0; e.busy = 1; e.clr = 1; e.src = (l != 0); e.layer = 4'(l); e.t = tt;
      push(e, m_full);
      for (int i = 0; i < n; i++) begin
        e = '0; e.busy = 1; e.en = 1; e.idx = 5'(i); e.sel = 32'd1 << i;
        e.src = (l != 0); e.layer = 4'(l); e.t = tt;
        push(e, m_full);
      end
      for (int d = 0; d < lat; d++) begin
        e = '0; e.busy = 1; e.layer = 4'(l); e.t = tt;
        push(e, m_ctl);
      end
      e = '0; e.busy = 1; e.ld = 1; e.layer = 4'(l); e.t = tt;
      push(e, m_ctl);
      tt = ~tt;
    end
    e = '0; e.busy = 1; e.done = 1; e.t = tt;
    push(e, m_tail);
    for (int k = 0; k < tail; k++) begin
      e = '0; e.t = tt;
      push(e, m_tail);
    end
    mt[which] = tt;
  endfunction

  // Launch a pass and record ncyc cycles starting at the CLEAR cycle; start is re-pulsed at poke cycles.
  task automatic run(input bit which, input int n_in0, input int nl, input int ncyc,
                     input int poke1, input int poke2);
    @(posedge clk); #1;
    if (which) begin ifb.n_in0 = 6'(n_in0); ifb.n_layers = 4'(nl); ifb.start = 1'b1; end
    else       begin ifa.n_in0 = 6'(n_in0); ifa.n_layers = 4'(nl); ifa.start = 1'b1; end
    @(posedge clk); #1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    ifa.n_in0 = 6'($urandom); ifa.n_layers = 4'($urandom);
    ifb.n_in0 = 6'($urandom); ifb.n_layers = 4'($urandom);
    got_q.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      got_q.push_back(sample(which));
      ifa.start = (!which) && (c == poke1 || c == poke2);
      ifb.start = which && (c == poke1 || c == poke2);
    end
    ifa.start = 1'b0; ifb.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ifa.start = 1'b1; ifb.start = 1'b1;
    ifa.n_in0 = 6'd3; ifa.n_layers = 4'd2; ifb.n_in0 = 6'd3; ifb.n_layers = 4'd2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (sample(w[0]) !== rec_t'(0)) begin
          errors++;
          $display("FAIL reset dut%0d cyc %0d got %h exp 0", w, c, sample(w[0]));
        end
      end
    end
    rst = 1'b0; ifa.start = 1'b0; ifb.start = 1'b0;
    mt[0] = 1'b0; mt[1] = 1'b0;
  endtask

  task automatic test_basic;
    build(0, 3, 2, 2);
    run(0, 3, 2, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((got_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++;
        $display("FAIL basic cyc %0d got %h exp %h", i + 1, got_q[i] & msk_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({got_q[5].ld, got_q[5].t, got_q[18].ld, got_q[18].t, got_q[19].done, got_q[20].t, got_q[20].busy}
        !== 7'b1011100) begin
      errors++;
      $display("FAIL basic_milestones got ld6=%b t6=%b ld19=%b t19=%b done20=%b t21=%b busy21=%b exp 1011100",
               got_q[5].ld, got_q[5].t, got_q[18].ld, got_q[18].t, got_q[19].done, got_q[20].t, got_q[20].busy);
    end
  endtask

  task automatic test_boundary;
    int nins [3] = '{0, 40, 5};
    int nls  [3] = '{1, 1, 0};
    for (int k = 0; k < 3; k++) begin
      build(0, nins[k], nls[k], 2);
      run(0, nins[k], nls[k], exp_q.size(), 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ((got_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          errors++;
          $display("FAIL boundary%0d cyc %0d got %h exp %h", k, i + 1, got_q[i] & msk_q[i], exp_q[i]);
        end
      end
      if (k == 1) begin
        checks++;
        if ({got_q[32].sel, got_q[32].en, got_q[33].en} !== {32'h8000_0000, 2'b10}) begin
          errors++;
          $display("FAIL boundary_last_sel got %h en=%b next_en=%b exp 80000000 1 0",
                   got_q[32].sel, got_q[32].en, got_q[33].en);
        end
      end
    end
  endtask

  task automatic test_mac_lat0;
    build(1, 4, 2, 2);
    run(1, 4, 2, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((got_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++;
        $display("FAIL lat0 cyc %0d got %h exp %h", i + 1, got_q[i] & msk_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({got_q[4].en, got_q[5].ld} !== 2'b11) begin
      errors++;
      $display("FAIL lat0_gap got en5=%b ld6=%b exp 1 1", got_q[4].en, got_q[5].ld);
    end
  endtask

  task automatic test_start_ignored;
    build(0, 3, 2, 2);
    run(0, 3, 2, exp_q.size(), 3, 10);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((got_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++;
        $display("FAIL start_ignored cyc %0d got %h exp %h", i + 1, got_q[i] & msk_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      int n = 1 + k * 2;
      build(0, n, 1, 0);
      run(0, n, 1, exp_q.size(), 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ((got_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          errors++;
          $display("FAIL back_to_back%0d cyc %0d got %h exp %h", k, i + 1, got_q[i] & msk_q[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      bit w  = k[0];
      int n  = $urandom_range(0, 40);
      int nl = $urandom_range(0, 3);
      build(w, n, nl, 2);
      run(w, n, nl, exp_q.size(), 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ((got_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          errors++;
          $display("FAIL random%0d n_in0=%0d n_layers=%0d cyc %0d got %h exp %h",
                   k, n, nl, i + 1, got_q[i] & msk_q[i], exp_q[i]);
        end
        checks++;
        if (int'(got_q[i].clr) + int'(got_q[i].en) + int'(got_q[i].ld) > 1) begin
          errors++;
          $display("FAIL exclusive%0d cyc %0d got clr=%b en=%b ld=%b exp at most one",
                   k, i + 1, got_q[i].clr, got_q[i].en, got_q[i].ld);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    run(0, 3, 2, 10, 0, 0);
    checks++;
    if ({got_q[9].en, got_q[9].src} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_setup got en=%b src=%b exp 1 1", got_q[9].en, got_q[9].src);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (sample(w[0]) !== rec_t'(0)) begin
        errors++;
        $display("FAIL reset_mid dut%0d got %h exp 0", w, sample(w[0]));
      end
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if ({ifa.ld_val, ifa.done, ifa.busy} !== 3'b000) begin
        errors++;
        $display("FAIL reset_abort cyc %0d got ld=%b done=%b busy=%b exp 0 0 0",
                 c, ifa.ld_val, ifa.done, ifa.busy);
      end
    end
    mt[0] = 1'b0; mt[1] = 1'b0;
    build(0, 3, 2, 2);
    run(0, 3, 2, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((got_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++;
        $display("FAIL after_reset cyc %0d got %h exp %h", i + 1, got_q[i] & msk_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_mac_lat0();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
